// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the voice mixing path: the default sample width,
// the mid-scale code of that width, and the mixer sequencing states.
// Ports: none (package only).
// ---------------------------------------------------------------------------
package audio_pkg;

    localparam int CODE_WIDTH_DEFAULT = 10;

    // Offset-binary zero point for a sample of the given width.
    function automatic int mid_of(input int width);
        return 1 << (width - 1);
    endfunction

    localparam int MID_CODE = 1 << (CODE_WIDTH_DEFAULT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_MIX     = 2'd2,
        ST_PRESENT = 2'd3
    } mix_state_e;

endpackage

// File: rtl/mix_sat.sv
// ---------------------------------------------------------------------------
// mix_sat
// Combinational gain/saturation stage: arithmetic right shift of the signed
// voice sum, clamp to the signed range of one sample, then re-bias to
// offset-binary. The output register lives in the parent.
// Ports:
//   acc  in   ACC_W       signed sum of (code - mid) over all voices
//   code out  CODE_WIDTH  saturated offset-binary result
// ---------------------------------------------------------------------------
module mix_sat
    import audio_pkg::*;
#(
    parameter int CODE_WIDTH = CODE_WIDTH_DEFAULT,
    parameter int ACC_W      = CODE_WIDTH_DEFAULT + 3,
    parameter int GAIN_SHIFT = 2
) (
    input  logic signed [ACC_W-1:0]      acc,
    output logic        [CODE_WIDTH-1:0] code
);

    localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'(mid_of(CODE_WIDTH) - 1);
    localparam logic signed [ACC_W-1:0] S_MIN = -S_MAX - ACC_W'(1);

    logic signed [ACC_W-1:0] scaled;

    // Inside the clamp window, adding mid-scale is the same as flipping the
    // sign bit of the low CODE_WIDTH bits.
    always_comb begin
        scaled = acc >>> GAIN_SHIFT;
        if (scaled > S_MAX) begin
            code = '1;
        end else if (scaled < S_MIN) begin
            code = '0;
        end else begin
            code = {~scaled[CODE_WIDTH-1], scaled[CODE_WIDTH-2:0]};
        end
    end

endmodule

// File: rtl/voice_mix_scheduler.sv
// ---------------------------------------------------------------------------
// voice_mix_scheduler
// Shares one sampler/DAC slot among NUM_VOICES voice generators. Each
// synth_ready pulse starts a frame: every enabled voice is fetched in order
// 0..N-1 (one-hot voice_ready handshake), the samples are summed about
// mid-scale, scaled and saturated, and presented on scaled_synth_code.
// A voice that stays silent for TIMEOUT cycles is replaced by its last sample
// and counted in underrun_cnt.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   voice_en              per-voice enable, latched at frame start
//   voice_valid/code      per-voice sample handshake and data
//   voice_ready           one-hot fetch request
//   synth_ready           sampler slot pulse (starts a frame)
//   synth_valid           mixed sample valid (stays high once produced)
//   scaled_synth_code     mixed sample
//   underrun_cnt          saturating count of timed-out fetches
//   overrun               sticky: synth_ready arrived mid-frame
//   busy                  frame in progress (COLLECT or MIX)
// ---------------------------------------------------------------------------
module voice_mix_scheduler
    import audio_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int CODE_WIDTH = CODE_WIDTH_DEFAULT,
    parameter int GAIN_SHIFT = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_VOICES-1:0]            voice_en,
    input  logic [NUM_VOICES-1:0]            voice_valid,
    input  logic [NUM_VOICES*CODE_WIDTH-1:0] voice_code,
    output logic [NUM_VOICES-1:0]            voice_ready,
    input  logic                             synth_ready,
    output logic                             synth_valid,
    output logic [CODE_WIDTH-1:0]            scaled_synth_code,
    output logic [15:0]                      underrun_cnt,
    output logic                             overrun,
    output logic                             busy
);

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int ACC_W = CODE_WIDTH + $clog2(NUM_VOICES) + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CODE_WIDTH-1:0]   MID      = CODE_WIDTH'(mid_of(CODE_WIDTH));
    localparam logic signed [ACC_W-1:0] MID_ACC  = ACC_W'(mid_of(CODE_WIDTH));
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [TMO_W-1:0]        TMO_LAST = TMO_W'(TIMEOUT - 1);

    mix_state_e              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic [NUM_VOICES-1:0]   en_q, en_d;
    logic [NUM_VOICES-1:0]   ready_q, ready_d;
    logic [CODE_WIDTH-1:0]   last_q [NUM_VOICES];
    logic [CODE_WIDTH-1:0]   last_d [NUM_VOICES];
    logic [CODE_WIDTH-1:0]   code_q, code_d;
    logic                    valid_q, valid_d;
    logic [15:0]             underrun_q, underrun_d;
    logic                    overrun_q, overrun_d;

    logic [CODE_WIDTH-1:0]   code_in [NUM_VOICES];
    logic signed [ACC_W-1:0] contrib;
    logic                    advance;
    logic [CODE_WIDTH-1:0]   mix_code;

    mix_sat #(
        .CODE_WIDTH (CODE_WIDTH),
        .ACC_W      (ACC_W),
        .GAIN_SHIFT (GAIN_SHIFT)
    ) u_mix_sat (
        .acc  (acc_q),
        .code (mix_code)
    );

    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            code_in[i] = voice_code[i*CODE_WIDTH +: CODE_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            acc_q      <= '0;
            tmo_q      <= '0;
            en_q       <= '0;
            ready_q    <= '0;
            code_q     <= MID;
            valid_q    <= 1'b0;
            underrun_q <= '0;
            overrun_q  <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                last_q[i] <= MID;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            tmo_q      <= tmo_d;
            en_q       <= en_d;
            ready_q    <= ready_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
            for (int i = 0; i < NUM_VOICES; i++) begin
                last_q[i] <= last_d[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        tmo_d      = tmo_q;
        en_d       = en_q;
        code_d     = code_q;
        valid_d    = valid_q;
        underrun_d = underrun_q;
        overrun_d  = overrun_q;
        for (int i = 0; i < NUM_VOICES; i++) begin
            last_d[i] = last_q[i];
        end
        advance = 1'b0;
        contrib = '0;

        case (state_q)
            ST_IDLE, ST_PRESENT: begin
                if (synth_ready) begin
                    state_d = ST_COLLECT;
                    en_d    = voice_en;
                    idx_d   = '0;
                    acc_d   = '0;
                    tmo_d   = '0;
                end
            end
            ST_COLLECT: begin
                // A valid sample beats a simultaneous timeout.
                if (!en_q[idx_q]) begin
                    advance = 1'b1;
                end else if (ready_q[idx_q] && voice_valid[idx_q]) begin
                    advance       = 1'b1;
                    contrib       = $signed(ACC_W'(code_in[idx_q])) - MID_ACC;
                    last_d[idx_q] = code_in[idx_q];
                end else if (tmo_q == TMO_LAST) begin
                    advance = 1'b1;
                    contrib = $signed(ACC_W'(last_q[idx_q])) - MID_ACC;
                    if (underrun_q != 16'hFFFF) begin
                        underrun_d = underrun_q + 16'd1;
                    end
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end

                if (advance) begin
                    acc_d = acc_q + contrib;
                    tmo_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_MIX;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_MIX: begin
                code_d  = mix_code;
                valid_d = 1'b1;
                state_d = ST_PRESENT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (synth_ready && (state_q == ST_COLLECT || state_q == ST_MIX)) begin
            overrun_d = 1'b1;
        end

        // Request is derived from the next index so a back-to-back voice is
        // asked for in the same cycle the previous one resolves.
        ready_d = '0;
        if (state_d == ST_COLLECT && en_d[idx_d]) begin
            ready_d[idx_d] = 1'b1;
        end
    end

    assign voice_ready       = ready_q;
    assign synth_valid       = valid_q;
    assign scaled_synth_code = code_q;
    assign underrun_cnt      = underrun_q;
    assign overrun           = overrun_q;
    assign busy              = (state_q == ST_COLLECT) || (state_q == ST_MIX);

endmodule

// File: tb/tb_voice_mix_scheduler.sv
// ---------------------------------------------------------------------------
// tb_voice_mix_scheduler
// Scoreboard bench: each frame request pushes its expected result, and a
// negedge monitor pops and compares whenever a frame finishes (busy falls).
// A second instance with GAIN_SHIFT=0 shares all inputs so the clamp is
// exercised without a separate run.
// ---------------------------------------------------------------------------
module tb_voice_mix_scheduler;
    import audio_pkg::*;

    localparam int N = 4;
    localparam int W = 10;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   voice_en = '0;
    logic [N-1:0]   voice_valid = '0;
    logic [N*W-1:0] voice_code = '0;
    logic           synth_ready = 1'b0;

    logic [N-1:0]   voice_ready, voice_ready_g0;
    logic           synth_valid, synth_valid_g0;
    logic [W-1:0]   code, code_g0;
    logic [15:0]    underrun, underrun_g0;
    logic           overrun, overrun_g0;
    logic           busy, busy_g0;

    voice_mix_scheduler #(.NUM_VOICES(N), .CODE_WIDTH(W), .GAIN_SHIFT(2), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .voice_en(voice_en), .voice_valid(voice_valid),
        .voice_code(voice_code), .voice_ready(voice_ready), .synth_ready(synth_ready),
        .synth_valid(synth_valid), .scaled_synth_code(code), .underrun_cnt(underrun),
        .overrun(overrun), .busy(busy)
    );

    voice_mix_scheduler #(.NUM_VOICES(N), .CODE_WIDTH(W), .GAIN_SHIFT(0), .TIMEOUT(64)) dut_g0 (
        .clk(clk), .rst_n(rst_n), .voice_en(voice_en), .voice_valid(voice_valid),
        .voice_code(voice_code), .voice_ready(voice_ready_g0), .synth_ready(synth_ready),
        .synth_valid(synth_valid_g0), .scaled_synth_code(code_g0), .underrun_cnt(underrun_g0),
        .overrun(overrun_g0), .busy(busy_g0)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           code;
        int           code_g0;
        int           underrun;
        int           lat;
        logic [N-1:0] mask;
    } exp_t;

    exp_t         exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           start_cyc = 0;
    logic         busy_prev = 1'b0;
    logic [N-1:0] ready_seen = '0;
    int           ready2_cycles = 0;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Frame monitor: compares whenever a frame completes.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            busy_prev = 1'b0;
        end else begin
            if (busy) begin
                ready_seen = ready_seen | voice_ready;
                if (voice_ready[2]) ready2_cycles++;
            end
            if (busy_prev && !busy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_frame: got code %0d, expected no frame", code);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("code", int'(code), e.code);
                    checkOutput("code_g0", int'(code_g0), e.code_g0);
                    checkOutput("synth_valid", int'(synth_valid), 1);
                    checkOutput("underrun_cnt", int'(underrun), e.underrun);
                    checkOutput("ready_mask", int'(ready_seen), int'(e.mask));
                    if (e.lat >= 0) checkOutput("latency", cyc - start_cyc, e.lat);
                end
            end
            busy_prev = busy;
        end
    end

    task automatic applyStimulus(input logic [N-1:0] en, input logic [N-1:0] valid,
                                 input int c0, input int c1, input int c2, input int c3,
                                 input bit do_push, input int ecode, input int ecode_g0,
                                 input int eunder, input int elat, input logic [N-1:0] emask);
        exp_t e;
        @(negedge clk);
        voice_en      = en;
        voice_valid   = valid;
        voice_code    = {W'(c3), W'(c2), W'(c1), W'(c0)};
        ready_seen    = '0;
        ready2_cycles = 0;
        if (do_push) begin
            e.code = ecode; e.code_g0 = ecode_g0; e.underrun = eunder;
            e.lat = elat; e.mask = emask;
            exp_q.push_back(e);
        end
        start_cyc   = cyc;
        synth_ready = 1'b1;
        @(negedge clk);
        synth_ready = 1'b0;
    endtask

    task automatic waitFrame(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL frame_timeout: got no frame in %0d cycles, expected one", budget);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic checkReset();
        checkOutput("rst_ready", int'(voice_ready), 0);
        checkOutput("rst_code", int'(code), MID_CODE);
        checkOutput("rst_valid", int'(synth_valid), 0);
        checkOutput("rst_underrun", int'(underrun), 0);
        checkOutput("rst_overrun", int'(overrun), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_ready_g0", int'(voice_ready_g0), 0);
        checkOutput("rst_code_g0", int'(code_g0), MID_CODE);
        checkOutput("rst_busy_g0", int'(busy_g0), 0);
    endtask

    task automatic resetDut();
        @(negedge clk);
        voice_valid = '0;
        synth_ready = 1'b0;
        rst_n       = 1'b0;
        @(negedge clk);
        checkReset();
        rst_n = 1'b1;
    endtask

    task automatic waitReady2();
        int n = 0;
        while (!voice_ready[2] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!voice_ready[2]) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready2_wait: got voice_ready %0b, expected bit 2 set", voice_ready);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        checkReset();
        rst_n = 1'b1;

        // All four valid at 612: +400 >> 2 = 100.
        applyStimulus(4'b1111, 4'b1111, 612, 612, 612, 612, 1'b1, 612, 912, 0, 6, 4'b1111);
        waitFrame(200);
        // Full-scale positive and negative.
        applyStimulus(4'b1111, 4'b1111, 1023, 1023, 1023, 1023, 1'b1, 1023, 1023, 0, 6, 4'b1111);
        waitFrame(200);
        applyStimulus(4'b1111, 4'b1111, 0, 0, 0, 0, 1'b1, 0, 0, 0, 6, 4'b1111);
        waitFrame(200);
        // Only voices 0 and 2 enabled; 712 + 312 cancels about mid-scale.
        applyStimulus(4'b0101, 4'b0101, 712, 0, 312, 0, 1'b1, 512, 512, 0, 6, 4'b0101);
        waitFrame(200);
        // All voices disabled.
        applyStimulus(4'b0000, 4'b0000, 100, 200, 300, 400, 1'b1, 512, 512, 0, 6, 4'b0000);
        waitFrame(200);

        // Voice 2 silent after reset: its 512 default fills in.
        resetDut();
        applyStimulus(4'b1111, 4'b1011, 612, 612, 999, 612, 1'b1, 587, 812, 1, -1, 4'b1111);
        waitFrame(400);
        checkOutput("ready2_cycles_a", ready2_cycles, 64);
        // Voice 2 supplies 800, then falls silent and 800 is reused.
        applyStimulus(4'b1111, 4'b1111, 512, 512, 800, 512, 1'b1, 584, 800, 1, 6, 4'b1111);
        waitFrame(200);
        applyStimulus(4'b1111, 4'b1011, 512, 512, 0, 512, 1'b1, 584, 800, 2, -1, 4'b1111);
        waitFrame(400);
        // Valid arrives on the final timeout cycle: sample taken, no underrun.
        applyStimulus(4'b1111, 4'b1011, 512, 512, 100, 512, 1'b1, 409, 100, 2, -1, 4'b1111);
        waitReady2();
        repeat (63) @(negedge clk);
        voice_valid[2] = 1'b1;
        @(negedge clk);
        voice_valid[2] = 1'b0;
        waitFrame(400);
        checkOutput("ready2_cycles_b", ready2_cycles, 64);

        // Extra synth_ready during COLLECT: flagged, frame unaffected.
        checkOutput("overrun_before", int'(overrun), 0);
        applyStimulus(4'b1111, 4'b1111, 612, 612, 612, 612, 1'b1, 612, 912, 2, 6, 4'b1111);
        synth_ready = 1'b1;
        @(negedge clk);
        synth_ready = 1'b0;
        waitFrame(200);
        checkOutput("overrun_after", int'(overrun), 1);
        repeat (5) @(negedge clk);
        checkOutput("no_restart_busy", int'(busy), 0);

        // Reset in the middle of a stalled COLLECT aborts the frame.
        applyStimulus(4'b1111, 4'b0000, 700, 700, 700, 700, 1'b0, 0, 0, 0, -1, 4'b0000);
        repeat (5) @(negedge clk);
        checkOutput("midframe_busy", int'(busy), 1);
        resetDut();
        repeat (80) @(negedge clk);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_valid", int'(synth_valid), 0);
        checkOutput("abort_underrun", int'(underrun), 0);
        checkOutput("abort_code", int'(code), 512);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
